div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 divider for RISC-V M-extension DIV/DIVU/REM/REMU, located beside the ALU in the EX stage.
- It generates the DivStalled input of the hazard detection unit. While it is asserted, the hazard unit freezes F/D/E.
- The result is presented for one cycle so the divide instruction can advance into M.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  a divide instruction is in EX (opcode 0110011, funct7 0000001, funct3[2]=1).
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled with start.
- op_a  in  XLEN  dividend (forwarded EX operand A).
- op_b  in  XLEN  divisor (forwarded EX operand B).
- hold  in  1  MemStall from M; pipeline cannot advance this cycle.
- flush  in  1  EX flush (FlushE or redirect); aborts the operation.
- div_stalled  out  1  to hazard unit DivStalled.
- done  out  1  result valid this cycle.
- result  out  XLEN  quotient or remainder, per the latched funct3.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is synchronous, active-high, and forces state IDLE.
  - Reset values: done=0, result=0, div_stalled=0, internal registers=0.
  - div_stalled is gated low while rst=1.
- States:
  - IDLE: waiting for start.
  - CALC: one quotient bit per cycle.
  - DONE: result presented.
- IDLE:
  - If start && !flush: latch funct3, sign flags and |op_a|, |op_b| (absolute values only for signed ops). Clear the remainder register and set count=XLEN. Go to CALC.
  - div_stalled=1 combinationally in this same cycle, because the instruction is already in EX.
- CALC:
  - Each cycle: shift {rem,quot} left 1, trial-subtract the divisor from rem, and keep the difference if it is non-negative (quot LSB=1). count decrements.
  - div_stalled=1 throughout.
  - Go to DONE after the iteration where count hits 0, i.e. XLEN CALC cycles.
- DONE:
  - div_stalled=0, done=1, result driven from registered final values.
  - If hold=1: stay in DONE with result stable and the start input ignored.
  - Otherwise go to IDLE next cycle.
  - A start seen in the cycle after DONE belongs to the next instruction.
- Latency: the start cycle plus XLEN stall cycles gives XLEN+1 cycles with div_stalled=1. done appears in cycle XLEN+1 relative to start (cycle 0).
- Sign fix-up, applied when entering DONE:
  - Quotient is negated when sign(a)!=sign(b) and b!=0.
  - Remainder takes the sign of the dividend.
- Special cases, matching the RISC-V spec and held in result:
  - b=0: quotient all ones (DIV and DIVU); remainder = op_a.
  - Signed overflow (op_a = most negative value, op_b = -1): quotient = op_a, remainder = 0.
- flush:
  - In any state, flush=1 sends the next state to IDLE and drives done=0.
  - div_stalled is 0 in the flush cycle when the block is in IDLE; otherwise it follows the current state.
  - flush takes priority over start and hold.
- rst mid-operation: abandon the operation and return to IDLE; no done pulse.
- Operands:
  - op_a/op_b are sampled only in the start cycle.
  - Later changes from forwarding have no effect.

Optional Feature:
- Macro DIV_FAST_EN.
- When defined: divide-by-zero and signed-overflow are detected in the IDLE start cycle and the unit goes directly to DONE. div_stalled is asserted only in the start cycle, and done appears at cycle 1.
- When undefined: these cases run the full XLEN iterations. Timing is then uniform, and the results are identical to the fast path.

Test Plan:
- DIVU 100/7, no hold → div_stalled high cycles 0..32 (33 cycles), done=1 at cycle 33, result=14; REMU same operands → 2.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. With DIV_FAST_EN these give done at cycle 1; without it, done at cycle 33.
- DIVU 100/7 with hold=1 for 3 cycles in DONE → done and result=14 stay stable for 4 cycles, div_stalled=0, start ignored, then IDLE.
- flush at CALC cycle 10 → IDLE next cycle, no done pulse; a subsequent DIVU 9/3 gives 3 with full latency.
- rst pulsed mid-CALC → done=0, div_stalled=0 and result=0 the next cycle; a new start is accepted immediately.

Source files
------------

// File: rtl/div_unit_if.sv
// EX-stage divider handshake: instruction/operands in, stall/done/result out.
// Master is the pipeline (EX/hazard side); slave is the divider.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hold;
    logic            flush;
    logic            div_stalled;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, hold, flush,
        input  div_stalled, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, hold, flush,
        output div_stalled, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU/REM/REMU; done at cycle XLEN+1 after start (cycle 1 for b=0/overflow with DIV_FAST_EN).
// Stalls F/D/E via div_stalled from start through the last iteration; hold keeps the result in DONE, flush aborts.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            rem_sel_q, rem_sel_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            stall;
    logic            done;

    // Operand conditioning for the start cycle
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            b_zero;
    logic            ovf;

    assign is_signed = ~bus.funct3[0];
    assign a_neg     = is_signed & bus.op_a[XLEN-1];
    assign b_neg     = is_signed & bus.op_b[XLEN-1];
    assign a_abs     = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    assign b_abs     = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    assign b_zero    = (bus.op_b == '0);
    assign ovf       = is_signed && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor
    logic [XLEN+1:0] trial;
    logic            keep;
    logic [XLEN-1:0] rem_it, quot_it;
    logic [XLEN-1:0] q_fin, r_fin;

    assign trial   = {1'b0, rem_q, quot_q[XLEN-1]} - {2'b00, dvs_q};
    assign keep    = ~trial[XLEN+1];
    assign rem_it  = keep ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quot_q[XLEN-1]};
    assign quot_it = {quot_q[XLEN-2:0], keep};
    assign q_fin   = qneg_q ? (~quot_it + 1'b1) : quot_it;
    assign r_fin   = rneg_q ? (~rem_it + 1'b1) : rem_it;

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        stall     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall     = 1'b1;
                    rem_sel_d = bus.funct3[1];
                    qneg_d    = (a_neg ^ b_neg) & ~b_zero;
                    rneg_d    = a_neg;
                    quot_d    = a_abs;
                    dvs_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(XLEN);
                    state_d   = S_CALC;
`ifdef DIV_FAST_EN
                    if (b_zero || ovf) begin
                        state_d = S_DONE;
                        if (bus.funct3[1]) begin
                            result_d = ovf ? '0 : bus.op_a;
                        end else begin
                            result_d = b_zero ? '1 : bus.op_a;
                        end
                    end
`endif
                end
            end
            S_CALC: begin
                stall  = 1'b1;
                quot_d = quot_it;
                rem_d  = rem_it;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = rem_sel_q ? r_fin : q_fin;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!bus.hold) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d = S_IDLE;
            done    = 1'b0;
        end

        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign bus.div_stalled = stall;
    assign bus.done        = done;
    assign bus.result      = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus random ops through a result queue,
// with hand-written flush/reset/hold sequences.
module tb_div_unit;
    localparam int XLEN = 32;
    localparam int LAT  = 33;
`ifdef DIV_FAST_EN
    localparam int LAT_SP = 1;
`else
    localparam int LAT_SP = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold_n;
    } vec_t;

    vec_t        vt[16];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic        sgn;
        sgn = ~f3[0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return LAT_SP;
        return LAT;
    endfunction

    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold_n);
        int          cyc;
        int          stalls;
        bit          got;
        logic [31:0] res;
        logic [31:0] expv;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
        bus.hold = 1'b0; bus.flush = 1'b0;
        sb_q.push_back(exp);
        cyc = 0; stalls = 0; got = 1'b0; res = 'x;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (bus.div_stalled) stalls++;
            if (bus.done) begin
                got = 1'b1;
                res = bus.result;
            end else begin
                @(posedge clk); #1;
                bus.start  = 1'b0;
                bus.funct3 = 3'($urandom_range(4, 7));
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
                cyc++;
            end
        end
        expv = sb_q.pop_front();
        chk({nm, " done latency"}, 32'(cyc), 32'(lat));
        chk({nm, " stall cycles"}, 32'(stalls), 32'(lat));
        chk({nm, " result"}, res, expv);
        for (int i = 0; i < hold_n; i++) begin
            bus.hold = 1'b1; bus.start = 1'b1;
            @(negedge clk);
            chk({nm, " hold done"}, 32'(bus.done), 32'd1);
            chk({nm, " hold result"}, bus.result, expv);
            chk({nm, " hold stall"}, 32'(bus.div_stalled), 32'd0);
        end
        bus.hold = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk({nm, " done pulse end"}, 32'(bus.done), 32'd0);
        chk({nm, " idle stall"}, 32'(bus.div_stalled), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{"DIVU 100/7",  3'b101, 32'd100,        32'd7,          32'd14,         LAT,    0};
        vt[1]  = '{"REMU 100/7",  3'b111, 32'd100,        32'd7,          32'd2,          LAT,    0};
        vt[2]  = '{"DIV -7/2",    3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT,    0};
        vt[3]  = '{"REM -7/2",    3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT,    0};
        vt[4]  = '{"REM 7/-2",    3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          LAT,    0};
        vt[5]  = '{"DIV 5/0",     3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  LAT_SP, 0};
        vt[6]  = '{"REMU 5/0",    3'b111, 32'd5,          32'd0,          32'd5,          LAT_SP, 0};
        vt[7]  = '{"DIV ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_SP, 0};
        vt[8]  = '{"REM ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_SP, 0};
        vt[9]  = '{"DIVU 5/0",    3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  LAT_SP, 0};
        vt[10] = '{"REM -5/0",    3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  LAT_SP, 0};
        vt[11] = '{"DIVU max/1",  3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT,    0};
        vt[12] = '{"DIV -100/-7", 3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         LAT,    0};
        vt[13] = '{"REM -100/-7", 3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  LAT,    0};
        vt[14] = '{"DIVU big",    3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT,    0};
        vt[15] = '{"DIVU hold",   3'b101, 32'd100,        32'd7,          32'd14,         LAT,    3};

        // start asserted during reset must not raise div_stalled
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'd5; bus.op_b = 32'd0;
        bus.hold = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(bus.div_stalled), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;

        foreach (vt[i]) do_op(vt[i].name, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].hold_n);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_op("random", f3, a, b, model(f3, a, b), lat_of(f3, a, b), 0);
        end

        // flush at CALC cycle 10: back to IDLE, no done pulse
        begin
            int dones;
            @(posedge clk); #1;
            bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            bus.flush = 1'b1;
            @(negedge clk);
            chk("flush CALC stall", 32'(bus.div_stalled), 32'd1);
            chk("flush CALC done", 32'(bus.done), 32'd0);
            @(posedge clk); #1;
            bus.flush = 1'b0;
            @(negedge clk);
            chk("after flush stall", 32'(bus.div_stalled), 32'd0);
            dones = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.done) dones++;
            end
            chk("after flush done count", 32'(dones), 32'd0);
            do_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, LAT, 0);
        end

        // flush in the start cycle wins over start
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd3;
        @(negedge clk);
        chk("flush IDLE stall", 32'(bus.div_stalled), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        chk("flush IDLE no start", 32'(bus.div_stalled), 32'd0);

        // reset mid-CALC
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid stall gated", 32'(bus.div_stalled), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst done", 32'(bus.done), 32'd0);
        chk("post rst stall", 32'(bus.div_stalled), 32'd0);
        chk("post rst result", bus.result, 32'd0);
        do_op("post rst DIVU", 3'b101, 32'd100, 32'd7, 32'd14, LAT, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
